// File: rtl/module_seg_mux_n.sv
// Time-multiplexed 7-segment driver for N BCD digits with tear-free frame updates,
// per-digit dwell, all-off anti-ghosting gap and optional leading-zero blanking.
module module_seg_mux_n #(
   parameter int unsigned N_DIGITS     = 4,
   parameter int unsigned DWELL_CYCLES = 50000,
   parameter int unsigned GAP_CYCLES   = 8,
   parameter int unsigned SEG_ACT_LOW  = 1,
   parameter int unsigned AN_ACT_HIGH  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*N_DIGITS-1:0]   bcd_in,
   input  logic                    listo,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic [N_DIGITS-1:0]     transis,
   output logic                    frame_tick
);

   localparam int unsigned BCD_W      = 4 * N_DIGITS;
   localparam int unsigned CNT_RANGE  = (DWELL_CYCLES > GAP_CYCLES)
                                        ? ((DWELL_CYCLES > 2) ? DWELL_CYCLES : 2)
                                        : ((GAP_CYCLES > 2) ? GAP_CYCLES : 2);
   localparam int unsigned CNT_W      = $clog2(CNT_RANGE);
   localparam int unsigned IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int unsigned DWELL_LAST = DWELL_CYCLES - 1;
   localparam int unsigned GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam int unsigned IDX_LAST   = N_DIGITS - 1;

   // Inactive output levels follow the configured polarities
   localparam logic [6:0]          SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [N_DIGITS-1:0] AN_OFF  = (AN_ACT_HIGH != 0) ? '0 : '1;

   typedef enum logic {
      SHOW = 1'b0,
      GAP  = 1'b1
   } state_t;

   state_t              state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [IDX_W-1:0]    idx, idx_n;
   logic                slot_end_c;
   logic                boundary_c;

   logic [BCD_W-1:0]    pend;
   logic                pend_v;
   logic [BCD_W-1:0]    disp;

   logic [3:0]          dig_c;
   logic                nz_c;
   logic                blank_c;
   logic [6:0]          code_c;
   logic [N_DIGITS-1:0] an_c;
   logic [6:0]          seg_nxt;
   logic [N_DIGITS-1:0] transis_nxt;

   // Scan state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= SHOW;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
      end
   end

   // Next-state: dwell/gap counting and digit advance; boundary = idx wrapping to 0
   always_comb begin
      state_n    = state;
      cnt_n      = cnt + CNT_W'(1);
      idx_n      = idx;
      slot_end_c = 1'b0;
      case (state)
         SHOW: begin
            if (cnt == CNT_W'(DWELL_LAST)) begin
               cnt_n = '0;
               if (GAP_CYCLES > 0) state_n = GAP;
               else                slot_end_c = 1'b1;
            end
         end
         GAP: begin
            if (cnt == CNT_W'(GAP_LAST)) begin
               cnt_n      = '0;
               state_n    = SHOW;
               slot_end_c = 1'b1;
            end
         end
         default: begin
            state_n = SHOW;
            cnt_n   = '0;
         end
      endcase
      if (slot_end_c) idx_n = (idx == IDX_W'(IDX_LAST)) ? '0 : idx + IDX_W'(1);
      boundary_c = slot_end_c && (idx == IDX_W'(IDX_LAST));
   end

   // Snapshot on listo; display copy only changes at a frame boundary
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend   <= '0;
         pend_v <= 1'b0;
         disp   <= '0;
      end else if (boundary_c) begin
         if (listo)       disp <= bcd_in;
         else if (pend_v) disp <= pend;
         pend_v <= 1'b0;
      end else if (listo) begin
         pend   <= bcd_in;
         pend_v <= 1'b1;
      end
   end

   // Current digit, enable pattern and leading-zero detection
   always_comb begin
      dig_c = 4'd0;
      nz_c  = 1'b0;
      an_c  = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            dig_c   = disp[4*i +: 4];
            an_c[i] = 1'b1;
         end
         if ((IDX_W'(i) >= idx) && (disp[4*i +: 4] != 4'd0)) nz_c = 1'b1;
      end
      blank_c = blank_lz && (idx != '0) && !nz_c;
   end

   // BCD to segments, 0 = lit; invalid nibbles show a, d, g
   always_comb begin
      code_c = 7'b0110110;
      case (dig_c)
         4'd0:    code_c = 7'b0000001;
         4'd1:    code_c = 7'b1001111;
         4'd2:    code_c = 7'b0010010;
         4'd3:    code_c = 7'b0000110;
         4'd4:    code_c = 7'b1001100;
         4'd5:    code_c = 7'b0100100;
         4'd6:    code_c = 7'b0100000;
         4'd7:    code_c = 7'b0001111;
         4'd8:    code_c = 7'b0000000;
         4'd9:    code_c = 7'b0000100;
         default: code_c = 7'b0110110;
      endcase
   end

   // Output values for the state currently held, with polarity applied
   always_comb begin
      seg_nxt     = SEG_OFF;
      transis_nxt = AN_OFF;
      if (state == SHOW) begin
         transis_nxt = (AN_ACT_HIGH != 0) ? an_c : ~an_c;
         if (!blank_c) seg_nxt = (SEG_ACT_LOW != 0) ? code_c : ~code_c;
      end
   end

   // Registered outputs, one cycle behind the scan state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg        <= SEG_OFF;
         transis    <= AN_OFF;
         frame_tick <= 1'b0;
      end else begin
         seg        <= seg_nxt;
         transis    <= transis_nxt;
         frame_tick <= boundary_c;
      end
   end

endmodule

// File: tb/tb_module_seg_mux_n.sv
// Scoreboard bench for module_seg_mux_n: a 4-digit instance (dwell 4, gap 1) and a
// 1-digit instance without gap (dwell 4).
module tb_module_seg_mux_n;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] S6 = 7'b0100000;
   localparam logic [6:0] S7 = 7'b0001111;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0000100;
   localparam logic [6:0] SX = 7'b0110110;
   localparam logic [6:0] SB = 7'b1111111;

   logic        clk;
   logic        rst;
   logic [15:0] bcd_in;
   logic        listo;
   logic        blank_lz;
   logic [6:0]  seg;
   logic [3:0]  transis;
   logic        frame_tick;

   logic [3:0]  bcd1;
   logic        listo1;
   logic [6:0]  seg1;
   logic [0:0]  transis1;
   logic        frame_tick1;

   typedef struct {
      bit         sof;
      logic [3:0] an;
      logic [6:0] seg;
      logic       tick;
      int         tag;
   } exp_t;

   exp_t q[$];
   exp_t q1[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   last_tick  = 1'b0;
   bit   last_tick1 = 1'b0;

   module_seg_mux_n #(
      .N_DIGITS(4), .DWELL_CYCLES(4), .GAP_CYCLES(1), .SEG_ACT_LOW(1), .AN_ACT_HIGH(1)
   ) dut (
      .clk(clk), .rst(rst), .bcd_in(bcd_in), .listo(listo), .blank_lz(blank_lz),
      .seg(seg), .transis(transis), .frame_tick(frame_tick)
   );

   module_seg_mux_n #(
      .N_DIGITS(1), .DWELL_CYCLES(4), .GAP_CYCLES(0), .SEG_ACT_LOW(1), .AN_ACT_HIGH(1)
   ) dut1 (
      .clk(clk), .rst(rst), .bcd_in(bcd1), .listo(listo1), .blank_lz(1'b0),
      .seg(seg1), .transis(transis1), .frame_tick(frame_tick1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor for the 4-digit instance: a frame-start entry waits for the tick before it
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0 && (!q[0].sof || last_tick)) begin
         e = q.pop_front();
         n_tests++;
         if (transis !== e.an || seg !== e.seg || frame_tick !== e.tick) begin
            n_fail++;
            $display("FAIL main t%0d: got an=%b seg=%b tick=%b, want an=%b seg=%b tick=%b",
                     e.tag, transis, seg, frame_tick, e.an, e.seg, e.tick);
         end
      end
      last_tick = frame_tick;
   end

   // Monitor for the 1-digit instance
   always @(negedge clk) begin
      exp_t e;
      if (q1.size() > 0 && (!q1[0].sof || last_tick1)) begin
         e = q1.pop_front();
         n_tests++;
         if ({3'b000, transis1} !== e.an || seg1 !== e.seg || frame_tick1 !== e.tick) begin
            n_fail++;
            $display("FAIL one t%0d: got an=%b seg=%b tick=%b, want an=%b seg=%b tick=%b",
                     e.tag, transis1, seg1, frame_tick1, e.an, e.seg, e.tick);
         end
      end
      last_tick1 = frame_tick1;
   end

   // Expected 20-cycle frame: 4 slots of (4 dwell + 1 gap); tick rides on the last gap
   task automatic push_frame(input logic [27:0] codes, input bit sof, input int nent,
                             input int tag);
      exp_t e;
      int   slot;
      for (int f = 0; f < nent; f++) begin
         slot  = f / 5;
         e.sof = sof && (f == 0);
         e.tag = tag;
         if ((f % 5) < 4) begin
            e.an  = 4'(1 << slot);
            e.seg = codes[7*slot +: 7];
         end else begin
            e.an  = 4'b0000;
            e.seg = SB;
         end
         e.tick = (f == 19);
         q.push_back(e);
      end
   endtask

   // Expected 4-cycle frame of the single-digit instance
   task automatic push_frame1(input logic [6:0] code, input bit sof, input int tag);
      exp_t e;
      for (int f = 0; f < 4; f++) begin
         e.sof  = sof && (f == 0);
         e.an   = 4'b0001;
         e.seg  = code;
         e.tick = (f == 3);
         e.tag  = tag;
         q1.push_back(e);
      end
   endtask

   task automatic push_off(input int tag);
      exp_t e;
      e.sof  = 1'b0;
      e.an   = 4'b0000;
      e.seg  = SB;
      e.tick = 1'b0;
      e.tag  = tag;
      q.push_back(e);
      q1.push_back(e);
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin
         @(posedge clk) #1;
         n++;
      end while (!frame_tick && n < 100);
      if (!frame_tick) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_tick: got frame_tick=0 after 100 cycles, want 1");
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || q1.size() != 0) && n < 200) begin
         @(posedge clk) #1;
         n++;
      end
      if (q.size() != 0 || q1.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d/%0d entries pending, want 0/0", q.size(), q1.size());
         q.delete();
         q1.delete();
      end
   endtask

   // Hold reset two cycles, release, then expect the zero display and a first load on dut1
   task automatic do_reset(input int tag);
      rst    = 1'b0;
      listo  = 1'b0;
      listo1 = 1'b0;
      push_off(tag);
      @(posedge clk) #1;
      push_off(tag);
      @(posedge clk) #1;
      rst    = 1'b1;
      listo1 = 1'b1;
      bcd1   = 4'h9;
      @(posedge clk) #1;
      listo1 = 1'b0;
      push_frame({S0, S0, S0, S0}, 1'b0, 20, tag);
      push_frame({S0, S0, S0, S0}, 1'b1, 20, tag);
      push_frame1(S0, 1'b0, tag);
      push_frame1(S9, 1'b1, tag);
   endtask

   initial begin
      rst      = 1'b0;
      bcd_in   = 16'h0000;
      listo    = 1'b0;
      blank_lz = 1'b0;
      bcd1     = 4'h0;
      listo1   = 1'b0;
      @(posedge clk) #1;

      // Reset and idle scan
      do_reset(1);
      drain();

      // Mid-frame load waits for the frame boundary
      wait_tick();
      bcd_in = 16'h1234;
      listo  = 1'b1;
      push_frame({S0, S0, S0, S0}, 1'b1, 20, 2);
      push_frame({S1, S2, S3, S4}, 1'b1, 20, 2);
      @(posedge clk) #1;
      listo = 1'b0;
      drain();

      // Leading-zero blanking
      wait_tick();
      bcd_in   = 16'h0070;
      listo    = 1'b1;
      blank_lz = 1'b1;
      push_frame({S1, S2, S3, S4}, 1'b1, 20, 3);
      push_frame({SB, SB, S7, S0}, 1'b1, 20, 3);
      @(posedge clk) #1;
      listo = 1'b0;
      drain();

      // blank_lz takes effect live
      wait_tick();
      blank_lz = 1'b0;
      push_frame({S0, S0, S7, S0}, 1'b1, 20, 4);
      drain();

      // Invalid nibbles
      wait_tick();
      bcd_in = 16'hA5F9;
      listo  = 1'b1;
      push_frame({S0, S0, S7, S0}, 1'b1, 20, 5);
      push_frame({SX, S5, SX, S9}, 1'b1, 20, 5);
      @(posedge clk) #1;
      listo = 1'b0;
      drain();

      // Invalid nibble counts as non-zero for blanking
      wait_tick();
      bcd_in   = 16'h0B00;
      listo    = 1'b1;
      blank_lz = 1'b1;
      push_frame({SX, S5, SX, S9}, 1'b1, 20, 6);
      push_frame({SB, SX, S0, S0}, 1'b1, 20, 6);
      @(posedge clk) #1;
      listo = 1'b0;
      drain();
      blank_lz = 1'b0;

      // Two loads in one frame: last one wins
      wait_tick();
      bcd_in = 16'h1111;
      listo  = 1'b1;
      push_frame({S0, SX, S0, S0}, 1'b1, 20, 7);
      push_frame({S2, S2, S2, S2}, 1'b1, 20, 7);
      @(posedge clk) #1;
      bcd_in = 16'h2222;
      @(posedge clk) #1;
      listo = 1'b0;
      drain();

      // Load exactly in the boundary cycle applies to the very next frame
      wait_tick();
      push_frame({S2, S2, S2, S2}, 1'b1, 20, 8);
      push_frame({S5, S6, S7, S8}, 1'b1, 20, 8);
      repeat (19) @(posedge clk) #1;
      bcd_in = 16'h5678;
      listo  = 1'b1;
      @(posedge clk) #1;
      listo = 1'b0;
      drain();

      // Reset during the digit-2 dwell
      wait_tick();
      push_frame({S5, S6, S7, S8}, 1'b1, 11, 9);
      repeat (12) @(posedge clk) #1;
      do_reset(10);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
